// File: rtl/hazard_pkg.sv
// Shared types and encodings for the ID-stage hazard unit.
// Pure declarations: no latency, no flow control.
package hazard_pkg;

  localparam int RA_W_DEF = 5;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hz_state_e;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_LU   = 2'd1;
  localparam logic [1:0] CAUSE_BR   = 2'd2;
  localparam logic [1:0] CAUSE_FRZ  = 2'd3;

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating event counter; counts one per enabled cycle and sticks at all-ones.
// Latency: one clock from enable to count; no backpressure, async active-low clear.
module hazard_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
    end else if (en && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// ID-stage hazard unit: load-use / branch-operand stalls, multi-cycle hold FSM, dmem freeze overlay.
// Latency: combinational detection to write enables; freeze overrides stalls and pauses the hold counter.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int RA_W     = RA_W_DEF,
  parameter int LOAD_LAT = 1,
  parameter int BR_IN_ID = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [RA_W-1:0]  id_rs_i,
  input  logic [RA_W-1:0]  id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic             id_branch_i,
  input  logic             ex_memrd_i,
  input  logic             ex_regwr_i,
  input  logic [RA_W-1:0]  ex_rd_i,
  input  logic             mem_memrd_i,
  input  logic [RA_W-1:0]  mem_rd_i,
  input  logic             dmem_stall_i,
  output logic             pc_wr_o,
  output logic             if_id_wr_o,
  output logic             id_ex_bubble_o,
  output logic             pipe_freeze_o,
  output logic             is_stall_o,
  output logic [1:0]       stall_cause_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] freeze_cnt_o
);

  localparam logic       BR_EN = (BR_IN_ID != 0);
  localparam logic [2:0] LU_N  = 3'(LOAD_LAT);
  localparam logic [2:0] BL_N  = 3'(LOAD_LAT + 1);

  hz_state_e  state_q;
  logic [1:0] rem_q;
  logic [1:0] cause_q;

  logic       m_ex, m_mem;
  logic       lu, be, bl, bm;
  logic       br_hit, haz;
  logic [2:0] need;
  logic [1:0] haz_cause;

  // Register 0 is hard-wired, so it never creates a dependency.
  assign m_ex  = ((id_use_rs_i && (id_rs_i == ex_rd_i)) ||
                  (id_use_rt_i && (id_rt_i == ex_rd_i))) && (ex_rd_i != '0);
  assign m_mem = ((id_use_rs_i && (id_rs_i == mem_rd_i)) ||
                  (id_use_rt_i && (id_rt_i == mem_rd_i))) && (mem_rd_i != '0);

  assign lu = ex_memrd_i && m_ex;
  assign be = BR_EN && id_branch_i && ex_regwr_i && !ex_memrd_i && m_ex;
  assign bl = BR_EN && id_branch_i && ex_memrd_i && m_ex;
  assign bm = BR_EN && id_branch_i && mem_memrd_i && m_mem;

  assign br_hit    = be || bl || bm;
  assign haz_cause = br_hit ? CAUSE_BR : CAUSE_LU;
  assign haz       = (need != 3'd0);

  always_comb begin
    need = 3'd0;
    if (lu && (LU_N > need)) need = LU_N;
    if (bl && (BL_N > need)) need = BL_N;
    if ((be || bm) && (need < 3'd1)) need = 3'd1;
  end

  // The first bubble is issued from RUN; HOLD covers the remaining need-1.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      rem_q   <= 2'd0;
      cause_q <= CAUSE_NONE;
    end else if (!dmem_stall_i) begin
      case (state_q)
        RUN: begin
          if (haz && (need > 3'd1)) begin
            state_q <= HOLD;
            rem_q   <= 2'(need - 3'd1);
            cause_q <= haz_cause;
          end
        end
        HOLD: begin
          rem_q <= rem_q - 2'd1;
          if (rem_q == 2'd1) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  always_comb begin
    pc_wr_o        = 1'b1;
    if_id_wr_o     = 1'b1;
    id_ex_bubble_o = 1'b0;
    pipe_freeze_o  = 1'b0;
    is_stall_o     = 1'b0;
    stall_cause_o  = CAUSE_NONE;
    if (!rst_i) begin
      pc_wr_o        = 1'b0;
      if_id_wr_o     = 1'b0;
      id_ex_bubble_o = 1'b1;
    end else if (dmem_stall_i) begin
      pc_wr_o       = 1'b0;
      if_id_wr_o    = 1'b0;
      pipe_freeze_o = 1'b1;
      stall_cause_o = CAUSE_FRZ;
    end else if (state_q == HOLD) begin
      pc_wr_o        = 1'b0;
      if_id_wr_o     = 1'b0;
      id_ex_bubble_o = 1'b1;
      is_stall_o     = 1'b1;
      stall_cause_o  = cause_q;
    end else if (haz) begin
      pc_wr_o        = 1'b0;
      if_id_wr_o     = 1'b0;
      id_ex_bubble_o = 1'b1;
      is_stall_o     = 1'b1;
      stall_cause_o  = haz_cause;
    end
  end

  hazard_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk    (clk_i),
    .arst_n (rst_i),
    .en     (is_stall_o),
    .cnt    (stall_cnt_o)
  );

  hazard_sat_cnt #(.CNT_W(CNT_W)) u_freeze_cnt (
    .clk    (clk_i),
    .arst_n (rst_i),
    .en     (pipe_freeze_o),
    .cnt    (freeze_cnt_o)
  );

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Parametrised hazard detection unit for the 5-stage MIPS pipeline, sitting in ID beside the register file.
- Detects load-use hazards, branch-in-ID operand hazards and data-memory miss freezes.
- Drives PC/IF-ID write enables, the ID/EX bubble mux select and a whole-pipeline freeze.
- Holds multi-cycle stalls with an internal counter FSM and keeps saturating stall statistics.

## Interface
Parameters:
- RA_W, 5: register address width.
- LOAD_LAT, 1: load-use bubbles required (1..3).
- BR_IN_ID, 1: 1 = branches resolve in ID and need operand hazard checks; 0 = branch checks disabled.
- CNT_W, 16: statistics counter width.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset. One clock; reset is asynchronous and active-low.
- id_rs_i / id_rt_i, in, RA_W: source registers of the instruction in ID.
- id_use_rs_i / id_use_rt_i, in, 1: the ID instruction actually reads rs / rt.
- id_branch_i, in, 1: the ID instruction is beq/bne.
- ex_memrd_i, in, 1: the EX instruction is a load.
- ex_regwr_i, in, 1: the EX instruction writes a register.
- ex_rd_i, in, RA_W: EX destination, after the RegDst mux.
- mem_memrd_i, in, 1: the MEM instruction is a load.
- mem_rd_i, in, RA_W: MEM destination.
- dmem_stall_i, in, 1: data memory miss in progress.
- pc_wr_o, out, 1: PC write enable.
- if_id_wr_o, out, 1: IF/ID write enable.
- id_ex_bubble_o, out, 1: zero the ID/EX control fields.
- pipe_freeze_o, out, 1: hold ID/EX, EX/MEM and MEM/WB.
- is_stall_o, out, 1: bubble being inserted this cycle.
- stall_cause_o, out, 2: 0 none, 1 load-use, 2 branch, 3 freeze.
- stall_cnt_o, out, CNT_W: bubble cycles seen.
- freeze_cnt_o, out, CNT_W: freeze cycles seen.

## Operation
Matching rules:
- A source matches a destination only if its use bit is set, the addresses are equal and the destination is not register 0.

Hazard terms, evaluated in RUN:
- LU: ex_memrd_i & (rs or rt matches ex_rd_i). Bubbles needed: LOAD_LAT.
- BE (BR_IN_ID=1): id_branch_i & ex_regwr_i & ~ex_memrd_i & match ex_rd_i. Bubbles needed: 1.
- BL (BR_IN_ID=1): id_branch_i & ex_memrd_i & match ex_rd_i. Bubbles needed: LOAD_LAT+1.
- BM (BR_IN_ID=1): id_branch_i & mem_memrd_i & match mem_rd_i. Bubbles needed: 1.
- When several terms are true, take the maximum bubble count. Cause is branch if any B* term is true, otherwise load-use.

FSM states RUN and HOLD, with a down-counter rem (2 bits).
- RUN, hazard with n bubbles: stall this cycle. If n>1, load rem=n-1 and go to HOLD; otherwise stay in RUN.
- HOLD: stall unconditionally and decrement rem. At rem==1, return to RUN on the next edge. Hazard inputs are ignored in HOLD.

Stall outputs:
- pc_wr_o=0, if_id_wr_o=0, id_ex_bubble_o=1, is_stall_o=1, cause latched (registered in HOLD).
- No stall: pc_wr_o=1, if_id_wr_o=1, id_ex_bubble_o=0, is_stall_o=0, cause 0.

Freeze overlay (dmem_stall_i=1) takes priority:
- pc_wr_o=0, if_id_wr_o=0, id_ex_bubble_o=0, pipe_freeze_o=1, is_stall_o=0, cause 3.
- FSM state and rem hold; no new hazard is accepted.
- After freeze drops, evaluation resumes from the held state.

Counters:
- stall_cnt_o increments on every is_stall_o cycle; freeze_cnt_o increments on every freeze cycle.
- Both saturate at all-ones and never wrap.

## Timing
- Detection is combinational: zero latency from inputs to write enables in RUN.
- Stall length is exactly the required bubble count in cycles, excluding freeze cycles.
- While rst_i is low:
  - State RUN, rem 0, both counters 0.
  - pc_wr_o=0, if_id_wr_o=0, id_ex_bubble_o=1, pipe_freeze_o=0, is_stall_o=0, stall_cause_o=0.
- Reset asserted mid-HOLD aborts the stall immediately.
- First cycle after rst_i rises is RUN.
- dmem_stall_i asserted in the same cycle a hazard appears: freeze wins. The hazard is re-evaluated after the freeze.

## Structure
- Package hazard_pkg holds:
  - state enum {RUN, HOLD};
  - cause encodings CAUSE_NONE/LU/BR/FRZ;
  - default RA_W.
- Sub-module hazard_sat_cnt (parametrised CNT_W, enable, async active-low clear), instantiated twice.
- The FSM and matching logic stay in the top module.

## Test plan
- LOAD_LAT=1; lw $2 in EX, ID add uses rs=$2 → one cycle with pc_wr_o=0 and id_ex_bubble_o=1, cause 1, stall_cnt_o=1.
- ex_rd_i=0 with a load and id_rs_i=0 → no stall. Also id_use_rt_i=0 with an rt match → no stall.
- LOAD_LAT=2, BR_IN_ID=1; beq reading $5 with lw $5 in EX → 3 stall cycles, HOLD entered with rem=2, cause 2.
- Same beq, but $5 written by an add in EX → 1 stall. With lw $5 in MEM → 1 stall.
- Mid-HOLD, dmem_stall_i high for 4 cycles → pipe_freeze_o=1 for 4 cycles, rem unchanged, remaining bubbles issued afterwards. freeze_cnt_o=4.
- CNT_W=2, 5 stall cycles → stall_cnt_o stays at 3. rst_i low mid-HOLD → outputs at reset values immediately, counters cleared.
